// File: rtl/frame_ram_arbiter.sv
// frame_ram_arbiter
//   Shares one single-port 4096x16 frame RAM between the panel scan path
//   (reads) and a frame writer (writes). The RAM is split into two
//   2048-word banks: scan reads the display bank, the writer fills the back
//   bank, and a writer-requested swap only lands on a scan frame boundary.
//   This prevents the panel from showing a torn frame.
//
//   Build option: FRAME_RAM_DOUBLE_BUFFER_EN
//     defined   - two banks, swap FSM (IDLE/PENDING/SWAP)
//     undefined - single bank; bank bit forced to 0, swap acknowledged next cycle
//
// Ports
//   i_clk, i_rst_n              clock, synchronous active-low reset
//   i_scan_addr, i_scan_rd_stb  panel driver address / row-shift strobe
//   o_scan_data                 pixel word back to the panel driver
//   i_wr_addr/data/valid        writer request into the back bank
//   o_wr_ready                  writer grant
//   i_swap_req, o_swap_done     back bank complete / banks swapped pulses
//   o_disp_bank, o_frame_count  current display bank, frames scanned
//   o_ram_*, i_ram_rdata        RAM primitive port (rdata one cycle after re)
module frame_ram_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_scan_addr,
  input  logic              i_scan_rd_stb,
  output logic [DATA_W-1:0] o_scan_data,
  input  logic [ADDR_W-2:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic              i_swap_req,
  output logic              o_swap_done,
  output logic              o_disp_bank,
  output logic [7:0]        o_frame_count,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  output logic              o_ram_we,
  output logic              o_ram_re,
  input  logic [DATA_W-1:0] i_ram_rdata
);

  localparam int BANK_W = ADDR_W - 1;

  logic [BANK_W-1:0] scan_off;
  logic [BANK_W-1:0] last_addr;
  logic              refetch;
  logic              scan_fetch;
  logic              fetch_q;
  logic [DATA_W-1:0] hold_q;
  logic              stb_q;
  logic              boundary;
  logic              wr_fire;
  logic              wr_bank;
  logic              disp_bank;
  logic              swap_now;
  logic              idle_ok;

  // Top address bit of the scan bus carries no meaning here; the bank comes
  // from disp_bank.
  logic scan_addr_unused;
  assign scan_addr_unused = i_scan_addr[ADDR_W-1];

  assign scan_off = i_scan_addr[BANK_W-1:0];

  // Fetch is driven purely by address change (not the strobe), so the first
  // word of the next row is prefetched during blanking.
  assign scan_fetch = i_rst_n & ((scan_off != last_addr) | refetch);

  // Strobe falling while the address has wrapped to 0 marks end of row 31.
  assign boundary = stb_q & ~i_scan_rd_stb & (scan_off == '0);

  assign o_wr_ready  = i_rst_n & ~scan_fetch & idle_ok;
  assign wr_fire     = i_wr_valid & o_wr_ready;

  // Scan and write are mutually exclusive by construction of o_wr_ready.
  assign o_ram_re    = scan_fetch;
  assign o_ram_we    = wr_fire;
  assign o_ram_wdata = i_wr_data;
  assign o_ram_addr  = wr_fire ? {wr_bank, i_wr_addr} : {disp_bank, scan_off};

  // Bypass the RAM output in the cycle it arrives so the driver sees data at
  // t+1; afterwards replay it from the hold register.
  assign o_scan_data = !i_rst_n ? '0 : (fetch_q ? i_ram_rdata : hold_q);

  assign o_disp_bank = disp_bank;

  // Scan side state: last fetched address, refetch flag, data hold, strobe
  // edge detect and frame counter.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      last_addr     <= '0;
      refetch       <= 1'b1;
      fetch_q       <= 1'b0;
      hold_q        <= '0;
      stb_q         <= 1'b0;
      o_frame_count <= '0;
    end else begin
      fetch_q <= scan_fetch;
      stb_q   <= i_scan_rd_stb;
      if (scan_fetch) last_addr <= scan_off;
      if (fetch_q)    hold_q    <= i_ram_rdata;
      // A swap forces a fresh fetch from the new bank even if the address is
      // unchanged; it takes priority over the clear from a same-cycle fetch.
      if (swap_now)        refetch <= 1'b1;
      else if (scan_fetch) refetch <= 1'b0;
      if (boundary) o_frame_count <= o_frame_count + 8'd1;
    end
  end

`ifdef FRAME_RAM_DOUBLE_BUFFER_EN

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_SWAP    = 2'd2
  } swap_state_t;

  swap_state_t state, state_nxt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      disp_bank <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_SWAP) disp_bank <= ~disp_bank;
    end
  end

  // A req coinciding with a boundary in IDLE still goes to PENDING, so the
  // swap waits a full frame; this keeps the writer's last frame intact.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (i_swap_req) state_nxt = S_PENDING;
      S_PENDING: if (boundary)   state_nxt = S_SWAP;
      S_SWAP:                    state_nxt = S_IDLE;
      default:                   state_nxt = S_IDLE;
    endcase
  end

  assign swap_now    = (state == S_SWAP);
  assign idle_ok     = (state == S_IDLE);
  assign o_swap_done = i_rst_n & swap_now;
  assign wr_bank     = ~disp_bank;

`else

  // Single bank: nothing to swap, the request is simply acknowledged.
  logic swap_done_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) swap_done_q <= 1'b0;
    else          swap_done_q <= i_swap_req;
  end

  assign disp_bank   = 1'b0;
  assign swap_now    = 1'b0;
  assign idle_ok     = 1'b1;
  assign o_swap_done = i_rst_n & swap_done_q;
  assign wr_bank     = 1'b0;

`endif

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Directed bench for frame_ram_arbiter with a behavioural single-port RAM.
module tb_frame_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] scan_addr;
  logic        scan_stb;
  logic [15:0] scan_data;
  logic [10:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic        swap_req;
  logic        swap_done;
  logic        disp_bank;
  logic [7:0]  frame_count;
  logic [11:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic        ram_re;
  logic [15:0] ram_rdata;

  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [15:0] pl_data = '0;
  logic [15:0] mem [0:4095];

  int checks = 0;
  int failures = 0;
  int exp_fc = 0;

  always #5 clk = ~clk;

  frame_ram_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_scan_addr(scan_addr), .i_scan_rd_stb(scan_stb), .o_scan_data(scan_data),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
    .i_swap_req(swap_req), .o_swap_done(swap_done),
    .o_disp_bank(disp_bank), .o_frame_count(frame_count),
    .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata), .o_ram_we(ram_we), .o_ram_re(ram_re),
    .i_ram_rdata(ram_rdata)
  );

  // RAM model; rdata is junk unless a read was issued, so a missing hold
  // register shows up.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_re ? mem[ram_addr] : 16'hDEAD;
  end

  // Inputs change 1 time unit after the rising edge; checks land 3 later.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic preload(input logic [11:0] a, input logic [15:0] d);
    tick(); pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick(); pl_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; scan_addr = 12'h123; scan_stb = 1'b0; wr_addr = '0; wr_data = '0;
    wr_valid = 1'b0; swap_req = 1'b0;
    tick(); tick(); #3;
    checks++; if (ram_re !== 1'b0) begin failures++; $display("FAIL rst_re: got %h want 0", ram_re); end
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL rst_wr_ready: got %h want 0", wr_ready); end
    checks++; if (disp_bank !== 1'b0) begin failures++; $display("FAIL rst_disp_bank: got %h want 0", disp_bank); end
    checks++; if (frame_count !== 8'd0) begin failures++; $display("FAIL rst_frame_count: got %h want 0", frame_count); end
    checks++; if (scan_data !== 16'h0) begin failures++; $display("FAIL rst_scan_data: got %h want 0", scan_data); end
    checks++; if (swap_done !== 1'b0) begin failures++; $display("FAIL rst_swap_done: got %h want 0", swap_done); end
    tick(); rst_n = 1'b1; #3;
    checks++; if (ram_re !== 1'b1 || ram_addr !== 12'h123) begin failures++; $display("FAIL rst_first_fetch: got re=%h addr=%h want re=1 addr=123", ram_re, ram_addr); end
    tick(); #3;
    checks++; if (ram_re !== 1'b0 || wr_ready !== 1'b1) begin failures++; $display("FAIL rst_settle: got re=%h ready=%h want re=0 ready=1", ram_re, wr_ready); end
  endtask

  task automatic test_scan_read();
    preload(12'h004, 16'h1111);
    preload(12'h005, 16'hA5C3);
    tick(); scan_addr = 12'h004; #3;
    checks++; if (ram_re !== 1'b1 || ram_addr !== 12'h004) begin failures++; $display("FAIL scan_fetch4: got re=%h addr=%h want re=1 addr=004", ram_re, ram_addr); end
    tick(); #3;
    checks++; if (scan_data !== 16'h1111) begin failures++; $display("FAIL scan_data4: got %h want 1111", scan_data); end
    tick(); scan_addr = 12'h005; #3;
    checks++; if (ram_re !== 1'b1 || ram_addr !== 12'h005 || ram_we !== 1'b0) begin failures++; $display("FAIL scan_fetch5: got re=%h addr=%h we=%h want re=1 addr=005 we=0", ram_re, ram_addr, ram_we); end
    checks++; if (scan_data !== 16'h1111) begin failures++; $display("FAIL scan_hold4: got %h want 1111", scan_data); end
    tick(); #3;
    checks++; if (scan_data !== 16'hA5C3 || ram_re !== 1'b0) begin failures++; $display("FAIL scan_data5: got data=%h re=%h want A5C3 re=0", scan_data, ram_re); end
    for (int i = 0; i < 3; i++) begin
      tick(); #3;
      checks++; if (scan_data !== 16'hA5C3) begin failures++; $display("FAIL scan_hold5[%0d]: got %h want A5C3", i, scan_data); end
    end
  endtask

  task automatic test_contention();
    int accepts = 0;
    int bad = 0;
    logic wbank;
`ifdef FRAME_RAM_DOUBLE_BUFFER_EN
    wbank = 1'b1;
`else
    wbank = 1'b0;
`endif
    tick(); scan_addr = 12'h000; tick(); tick();
    wr_addr = 11'h100; wr_data = 16'hC000;
    for (int k = 1; k <= 64; k++) begin
      for (int ph = 0; ph < 2; ph++) begin
        tick(); scan_addr = 12'(k); scan_stb = 1'b1; wr_valid = 1'b1; #3;
        checks++; if (ram_we && ram_re) begin failures++; $display("FAIL cont_we_re k=%0d: got both high want exclusive", k); end
        if (ram_we) begin
          checks++; if (ram_addr !== {wbank, wr_addr}) begin failures++; $display("FAIL cont_waddr k=%0d: got %h want %h", k, ram_addr, {wbank, wr_addr}); end
          accepts++;
          @(posedge clk); #1;
          wr_addr = wr_addr + 11'd1; wr_data = wr_data + 16'd1;
          #0;
          // re-enter same cycle position for the next phase
          ph = ph;
        end
        if (ram_we == 1'b0 && ph == 1) bad++;
      end
    end
    tick(); wr_valid = 1'b0; scan_stb = 1'b0;
    checks++; if (accepts != 64) begin failures++; $display("FAIL cont_accepts: got %0d want 64", accepts); end
    checks++; if (bad != 0) begin failures++; $display("FAIL cont_missed_grants: got %0d want 0", bad); end
    for (int i = 0; i < 64; i++) begin
      if (mem[{wbank, 11'(11'h100 + i)}] !== 16'(16'hC000 + i)) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL cont_mem: got %0d bad words want 0", bad); end
  endtask

  task automatic test_frame_boundary();
    tick(); scan_addr = 12'h7FF; scan_stb = 1'b1;
    tick(); scan_addr = 12'h000;
    tick(); scan_stb = 1'b0; #3;
    checks++; if (frame_count !== 8'(exp_fc)) begin failures++; $display("FAIL fb_before: got %0d want %0d", frame_count, exp_fc); end
    tick(); #3; exp_fc++;
    checks++; if (frame_count !== 8'(exp_fc)) begin failures++; $display("FAIL fb_incr: got %0d want %0d", frame_count, exp_fc); end
    tick(); scan_addr = 12'h005; scan_stb = 1'b1;
    tick(); scan_stb = 1'b0;
    tick(); #3;
    checks++; if (frame_count !== 8'(exp_fc)) begin failures++; $display("FAIL fb_nonzero_addr: got %0d want %0d", frame_count, exp_fc); end
    tick(); scan_addr = 12'h000;
    tick(); tick(); #3;
    checks++; if (frame_count !== 8'(exp_fc)) begin failures++; $display("FAIL fb_no_fall: got %0d want %0d", frame_count, exp_fc); end
  endtask

  task automatic boundary_seq();
    tick(); scan_addr = 12'h3FF; scan_stb = 1'b1;
    tick(); scan_addr = 12'h000;
    tick(); scan_stb = 1'b0;
  endtask

`ifdef FRAME_RAM_DOUBLE_BUFFER_EN
  task automatic test_swap_boundary();
    tick(); swap_req = 1'b1; wr_valid = 1'b1; wr_addr = 11'h020; wr_data = 16'h5A5A; #3;
    checks++; if (ram_we !== 1'b1 || ram_addr !== 12'h820) begin failures++; $display("FAIL sw_req_write: got we=%h addr=%h want we=1 addr=820", ram_we, ram_addr); end
    tick(); swap_req = 1'b0; #3;
    checks++; if (wr_ready !== 1'b0 || ram_we !== 1'b0) begin failures++; $display("FAIL sw_pending_block: got ready=%h we=%h want 0 0", wr_ready, ram_we); end
    tick(); swap_req = 1'b1; tick(); swap_req = 1'b0;
    boundary_seq(); #3;
    checks++; if (swap_done !== 1'b0 || wr_ready !== 1'b0) begin failures++; $display("FAIL sw_bcycle: got done=%h ready=%h want 0 0", swap_done, wr_ready); end
    tick(); #3; exp_fc++;
    checks++; if (swap_done !== 1'b1 || disp_bank !== 1'b0 || frame_count !== 8'(exp_fc)) begin failures++; $display("FAIL sw_done: got done=%h bank=%h fc=%0d want 1 0 %0d", swap_done, disp_bank, frame_count, exp_fc); end
    tick(); #3;
    checks++; if (swap_done !== 1'b0 || disp_bank !== 1'b1 || ram_re !== 1'b1 || ram_addr !== 12'h800) begin failures++; $display("FAIL sw_after: got done=%h bank=%h re=%h addr=%h want 0 1 1 800", swap_done, disp_bank, ram_re, ram_addr); end
    tick(); #3;
    checks++; if (ram_we !== 1'b1 || ram_addr !== 12'h020) begin failures++; $display("FAIL sw_newback: got we=%h addr=%h want 1 020", ram_we, ram_addr); end
    tick(); wr_valid = 1'b0;
  endtask

  task automatic test_simul_req_boundary();
    tick(); scan_addr = 12'h3FF; scan_stb = 1'b1;
    tick(); scan_addr = 12'h000;
    tick(); scan_stb = 1'b0; swap_req = 1'b1; #3;
    checks++; if (swap_done !== 1'b0) begin failures++; $display("FAIL sim_bcycle: got done=%h want 0", swap_done); end
    tick(); swap_req = 1'b0; #3; exp_fc++;
    checks++; if (swap_done !== 1'b0 || wr_ready !== 1'b0 || frame_count !== 8'(exp_fc)) begin failures++; $display("FAIL sim_no_swap: got done=%h ready=%h fc=%0d want 0 0 %0d", swap_done, wr_ready, frame_count, exp_fc); end
    for (int i = 0; i < 3; i++) begin
      tick(); #3;
      checks++; if (swap_done !== 1'b0 || disp_bank !== 1'b1) begin failures++; $display("FAIL sim_wait[%0d]: got done=%h bank=%h want 0 1", i, swap_done, disp_bank); end
    end
    boundary_seq();
    tick(); #3; exp_fc++;
    checks++; if (swap_done !== 1'b1) begin failures++; $display("FAIL sim_next_frame: got done=%h want 1", swap_done); end
    tick(); #3;
    checks++; if (disp_bank !== 1'b0) begin failures++; $display("FAIL sim_bank: got %h want 0", disp_bank); end
  endtask
`else
  task automatic test_single_bank();
    tick(); swap_req = 1'b1; #3;
    checks++; if (swap_done !== 1'b0) begin failures++; $display("FAIL sb_done_early: got %h want 0", swap_done); end
    tick(); swap_req = 1'b0; #3;
    checks++; if (swap_done !== 1'b1 || disp_bank !== 1'b0) begin failures++; $display("FAIL sb_done: got done=%h bank=%h want 1 0", swap_done, disp_bank); end
    tick(); #3;
    checks++; if (swap_done !== 1'b0) begin failures++; $display("FAIL sb_done_pulse: got %h want 0", swap_done); end
    tick(); wr_valid = 1'b1; wr_addr = 11'h010; wr_data = 16'hBEEF; #3;
    checks++; if (wr_ready !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 12'h010 || ram_wdata !== 16'hBEEF) begin failures++; $display("FAIL sb_write: got ready=%h we=%h addr=%h wdata=%h want 1 1 010 BEEF", wr_ready, ram_we, ram_addr, ram_wdata); end
    tick(); wr_valid = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
`ifdef FRAME_RAM_DOUBLE_BUFFER_EN
    tick(); swap_req = 1'b1;
    tick(); swap_req = 1'b0;
    repeat (100) tick();
    #3;
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL rm_pending: got ready=%h want 0", wr_ready); end
`endif
    tick(); scan_addr = 12'hAA5; scan_stb = 1'b1; wr_valid = 1'b1; wr_addr = 11'h033;
    tick(); rst_n = 1'b0; #3;
    checks++; if (ram_re !== 1'b0 || ram_we !== 1'b0 || wr_ready !== 1'b0 || swap_done !== 1'b0 || scan_data !== 16'h0) begin failures++; $display("FAIL rm_during: got re=%h we=%h ready=%h done=%h data=%h want all 0", ram_re, ram_we, wr_ready, swap_done, scan_data); end
    tick(); rst_n = 1'b1; #3;
    checks++; if (disp_bank !== 1'b0 || frame_count !== 8'd0) begin failures++; $display("FAIL rm_regs: got bank=%h fc=%0d want 0 0", disp_bank, frame_count); end
    checks++; if (ram_re !== 1'b1 || ram_addr !== 12'h2A5 || wr_ready !== 1'b0) begin failures++; $display("FAIL rm_refetch: got re=%h addr=%h ready=%h want 1 2A5 0", ram_re, ram_addr, wr_ready); end
    tick(); #3;
    checks++; if (wr_ready !== 1'b1 || ram_we !== 1'b1 || swap_done !== 1'b0) begin failures++; $display("FAIL rm_idle: got ready=%h we=%h done=%h want 1 1 0", wr_ready, ram_we, swap_done); end
    tick(); wr_valid = 1'b0; scan_stb = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan_read();
    test_contention();
    test_frame_boundary();
`ifdef FRAME_RAM_DOUBLE_BUFFER_EN
    test_swap_boundary();
    test_simul_req_boundary();
`else
    test_single_bank();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_ram_arbiter.md
# frame_ram_arbiter

Shares the single-port 4096×16 frame RAM between the panel scan path and a frame writer, such as the GIF frame loader. The RAM is split into two 2048-word banks, one per 64×32 frame. The scan path always reads the display bank; the writer fills the back bank. A swap is requested by the writer and takes effect only at a scan frame boundary, so the panel never shows a torn frame. The block sits between the panel driver's RAM interface and the RAM primitive.

## Interface
- ADDR_W, 12, RAM address width; bit ADDR_W-1 is the bank bit
- DATA_W, 16, RAM word width
- i_clk  in  1  system clock
- i_rst_n  in  1  synchronous active-low reset
- i_scan_addr  in  12  panel driver address; only [10:0] used
- i_scan_rd_stb  in  1  panel driver read strobe (high during row shift)
- o_scan_data  out  16  pixel word to panel driver
- i_wr_addr  in  11  writer word address within the back bank
- i_wr_data  in  16  writer data
- i_wr_valid  in  1  writer request
- o_wr_ready  out  1  write accepted this cycle when valid&ready
- i_swap_req  in  1  1-cycle pulse: back bank complete
- o_swap_done  out  1  1-cycle pulse: banks swapped
- o_disp_bank  out  1  current display bank
- o_frame_count  out  8  frames scanned, wraps 255→0
- o_ram_addr  out  12  RAM address
- o_ram_wdata  out  16  RAM write data
- o_ram_we  out  1  RAM write enable
- o_ram_re  out  1  RAM read enable
- i_ram_rdata  in  16  RAM read data, valid the cycle after o_ram_re

## Operation
- **Scan fetch:**
  - Condition: i_scan_addr[10:0] ≠ last fetched address, or refetch flag set.
  - Action: o_ram_re=1, o_ram_addr={disp_bank, i_scan_addr[10:0]}; record the address and clear refetch.
  - The condition is independent of i_scan_rd_stb, so the next row's first word is prefetched during blanking/latch.
- **Scan data:**
  - Cycle after a fetch: o_scan_data = i_ram_rdata (combinational bypass), which is also captured into the hold register.
  - Otherwise: o_scan_data = hold register.
- **Write grant:**
  - o_wr_ready = rst_n & ~scan_fetch_this_cycle & (swap_state==IDLE).
  - On valid&ready: o_ram_we=1, o_ram_addr={~disp_bank, i_wr_addr}, o_ram_wdata=i_wr_data.
  - Scan always wins; o_ram_we and o_ram_re are never high together.
- **Frame boundary:** i_scan_rd_stb falls (1 registered → 0 now) while i_scan_addr[10:0]==0, i.e. after the last pixel of row 31. o_frame_count increments.
- **Swap FSM:**
  - IDLE: i_swap_req → PENDING.
  - PENDING: o_wr_ready=0. Further i_swap_req ignored. Frame boundary → SWAP.
  - SWAP (one cycle): toggle disp_bank, set refetch, o_swap_done=1 → IDLE.
- **Simultaneous events:**
  - i_swap_req together with a boundary in IDLE → PENDING; the swap waits for the next boundary.
  - A write that is valid in the cycle i_swap_req arrives (IDLE, ready=1) is accepted.
- **Reset (any time, including mid-frame or PENDING):**
  - Outputs: o_ram_re=0, o_ram_we=0, o_wr_ready=0, o_swap_done=0, o_disp_bank=0, o_frame_count=0, o_scan_data=0.
  - Internal: FSM=IDLE, refetch=1, registered strobe=0.
  - RAM contents untouched.

## Timing
- Scan address change at cycle t → o_ram_re at t (combinational from i_scan_addr) → data on o_scan_data at t+1.
- Panel driver changes address at most every 2 cycles, so the writer gets ≥1 grant per 2 cycles during shift and every cycle otherwise.
- Swap latency: i_swap_req at t → PENDING at t+1. o_swap_done is the cycle after the boundary is detected.
- First fetch after a swap is the cycle after SWAP, from the new bank.
- o_frame_count updates the cycle after the boundary.

## Configuration
- FRAME_RAM_DOUBLE_BUFFER_EN defined: two-bank behaviour as above.
- Not defined: single bank.
  - Bank bit is forced to 0 for both scan and write.
  - i_swap_req → o_swap_done next cycle, with no PENDING state.
  - o_wr_ready depends only on scan fetch and reset.
  - o_disp_bank=0 constant.

## Test plan
- **Reset mid-PENDING:** swap_req, 100 cycles, rst_n=0 one cycle → disp_bank=0, wr_ready=0 during reset, FSM IDLE, first post-reset cycle issues ram_re at {0, scan_addr}.
- **Scan read path:** preload bank0[5]=0xA5C3; scan_addr 4→5 → ram_re, ram_addr=0x005 that cycle, o_scan_data=0xA5C3 next cycle and held while addr stays 5.
- **Contention:** wr_valid held with 64-pixel shift running → never we&re together, ~64 writes accepted per row, every write lands at 0x800|wr_addr while disp_bank=0.
- **Swap at boundary:** swap_req mid-row 10 → wr_ready=0 until the stb fall with scan_addr[10:0]=0; swap_done pulses once, disp_bank=1, next fetch at 0x800, frame_count +1.
- **Simultaneous req + boundary:** swap_req in the boundary cycle → no swap that frame, swap_done exactly one frame later.
- **Single-bank build (macro undefined):** swap_req → swap_done next cycle; writes to wr_addr 0x10 appear at ram_addr 0x010.
